gate_delay_meter: RTL and testbench
===================================

Name: gate_delay_meter

Overview:
- Characterises a gate-under-test (GUT), such as an xor, inverter, nor or nand instance with rise/fall delays.
- Drives a stimulus edge into the GUT, samples the asynchronous GUT output through a 2-flop synchroniser, and counts clock cycles until the expected response appears.
- Measures both stimulus edges: low→high, then high→low.
- Sits in the characterisation bench beside the gate primitives and reports cycle-quantised propagation delay.

Parameters:
- CNT_W, 8: width of the cycle counters and result registers.
- SETTLE, 16: cycles the stimulus is held steady before each measured edge. Must be ≥ 1.
- TIMEOUT, 200: maximum cycles per measurement. Must be ≤ 2^CNT_W − 1.
- INVERTING, 1: 1 means the GUT response is the inverse of the stimulus; 0 means non-inverting.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a measurement. Ignored while busy.
- dut_out  input  1  GUT output, asynchronous to clk.
- stim  output  1  registered drive to the GUT input.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are valid.
- lh_cycles  output  CNT_W  cycle count for the stimulus low→high edge.
- hl_cycles  output  CNT_W  cycle count for the stimulus high→low edge.
- timeout  output  1  sticky flag: a measurement reached TIMEOUT. Cleared on the next accepted start.

Behaviour:
- Reset: on rst sampled high, the block goes to IDLE.
  - stim=0, busy=0, done=0, lh_cycles=0, hl_cycles=0, timeout=0.
  - Synchroniser flops are set to 0.
  - Reset mid-measurement aborts immediately; no done pulse is produced.
- Synchroniser: sync1 <= dut_out, sync2 <= sync1. The FSM observes only sync2.
- Expected response level: exp(s) = s XOR INVERTING.
- FSM states:
  - IDLE: stim=0. On start, clear lh_cycles, hl_cycles and timeout, load settle counter, go to SET_LO.
  - SET_LO: stim=0. Count SETTLE cycles, then set stim<=1, clear cnt, go to MEAS_LH.
  - MEAS_LH: each cycle where sync2 ≠ exp(1), increment cnt.
    - When sync2 = exp(1): lh_cycles<=cnt, reload settle counter, go to SET_HI.
    - When cnt reaches TIMEOUT: lh_cycles<=TIMEOUT, timeout<=1, stim<=0, go to FIN. The falling edge is skipped and hl_cycles stays 0.
  - SET_HI: stim=1. Count SETTLE cycles, then set stim<=0, clear cnt, go to MEAS_HL.
  - MEAS_HL: same as MEAS_LH using exp(0); the result goes to hl_cycles. On timeout: hl_cycles<=TIMEOUT, timeout<=1.
  - FIN: done=1 for exactly one cycle, busy<=0, go to IDLE.
- Cycle quantisation: for GUT delay d (not an exact multiple of period T), raw count = ceil(d/T)+1. This includes the synchroniser latency. A sub-period delay reads 2.
- Counter width: cnt never exceeds TIMEOUT and never wraps.
- Results hold their values until the next accepted start.
- start while busy is ignored, with no effect on the state or the counters.
- start in the same cycle as rst: rst wins.
- Response already at the expected level when MEAS is entered (GUT faster than the settle window): count = 0.
- Glitches on dut_out: the first synchronised match ends the measurement; later toggles are ignored.

Optional Feature:
- Macro: GATE_DELAY_SYNC_COMP_EN.
- Defined: the result written to lh_cycles/hl_cycles is cnt−1, saturating at 0, so a measurement reads ceil(d/T). Timeout results are still exactly TIMEOUT.
- Not defined: raw cnt is reported as specified in Behaviour.

Test Plan:
- Inverting GUT model (output falls 37 ns after stim rises, rises 25 ns after stim falls), T=10 ns, defaults; start pulse → busy 1, done pulse after the second settle window, lh_cycles=5, hl_cycles=4, timeout=0. With GATE_DELAY_SYNC_COMP_EN: 4 and 3.
- INVERTING=0, buffer model with 12 ns delay both ways → lh_cycles=3, hl_cycles=3. Second start → identical results, and timeout is cleared at start.
- INVERTING=0, dut_out tied to 0, TIMEOUT=50 → lh_cycles=50, hl_cycles=0, timeout=1, done pulse, stim returns to 0.
- start re-pulsed every cycle during a measurement → exactly one done pulse; results equal the single-start run.
- rst asserted mid MEAS_HL → next cycle: stim=0, busy=0, all results 0, no done. A fresh start then completes normally.
- Sub-period delay (3 ns) with SETTLE=1 → counts 2/2. Response stuck at the expected level before the edge → count 0.

Source files
------------

// File: rtl/gate_delay_meter.sv
// Measures cycle-quantised rise/fall propagation delay of a gate-under-test.
// Optional build macro GATE_DELAY_SYNC_COMP_EN subtracts the synchroniser cycle from results.
module gate_delay_meter #(
  parameter int CNT_W     = 8,
  parameter int SETTLE    = 16,
  parameter int TIMEOUT   = 200,
  parameter bit INVERTING = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             stim,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lh_cycles,
  output logic [CNT_W-1:0] hl_cycles,
  output logic             timeout
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET_LO  = 3'd1;
  localparam logic [2:0] S_MEAS_LH = 3'd2;
  localparam logic [2:0] S_SET_HI  = 3'd3;
  localparam logic [2:0] S_MEAS_HL = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  localparam logic [CNT_W-1:0] TMO_VAL    = CNT_W'(TIMEOUT);
  localparam logic [SW-1:0]    SETTLE_TOP = SW'(SETTLE - 1);

  logic [2:0]       state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] lh_q, lh_d;
  logic [CNT_W-1:0] hl_q, hl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    settle_q, settle_d;

  logic             hit;
  logic             cnt_last;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] result;

  // While measuring, stim already holds the driven level, so the expected response is stim ^ INVERTING.
  assign hit      = (sync2_q == (stim_q ^ INVERTING));
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign cnt_last = (cnt_inc == (CNT_W + 1)'(TIMEOUT));

`ifdef GATE_DELAY_SYNC_COMP_EN
  assign result = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
`else
  assign result = cnt_q;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d  = state_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmo_d    = tmo_q;
    lh_d     = lh_q;
    hl_d     = hl_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: if (start) begin
        lh_d     = '0;
        hl_d     = '0;
        tmo_d    = 1'b0;
        busy_d   = 1'b1;
        settle_d = SETTLE_TOP;
        state_d  = S_SET_LO;
      end
      S_SET_LO, S_SET_HI: begin
        if (settle_q == '0) begin
          stim_d  = (state_q == S_SET_LO);
          cnt_d   = '0;
          state_d = (state_q == S_SET_LO) ? S_MEAS_LH : S_MEAS_HL;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_MEAS_LH, S_MEAS_HL: begin
        if (hit) begin
          if (state_q == S_MEAS_LH) begin
            lh_d     = result;
            settle_d = SETTLE_TOP;
            state_d  = S_SET_HI;
          end else begin
            hl_d    = result;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end else if (cnt_last) begin
          if (state_q == S_MEAS_LH) lh_d = TMO_VAL;
          else                      hl_d = TMO_VAL;
          tmo_d   = 1'b1;
          stim_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stim_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      lh_q     <= '0;
      hl_q     <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= dut_out;
      sync2_q  <= sync1_q;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      lh_q     <= lh_d;
      hl_q     <= hl_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign lh_cycles = lh_q;
  assign hl_cycles = hl_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_gate_delay_meter.sv
// Bench for gate_delay_meter: an inverting default-parameter instance and a
// non-inverting SETTLE=1 / TIMEOUT=50 instance, each driving a delay-modelled GUT.
`timescale 1ns/1ps
module tb_gate_delay_meter;

  localparam int T_NS  = 10;
  localparam int TMO_A = 200;
  localparam int TMO_B = 50;

  typedef struct {
    logic       stim;
    logic       busy;
    logic       done;
    logic [7:0] lh;
    logic [7:0] hl;
    logic       to;
  } obs_t;

  typedef struct {
    int inst;
    bit cst_en;
    bit cst_v;
    int dr;
    int df;
    int lh;
    int hl;
    bit to;
  } vec_t;

  logic clk = 1'b0;
  always #(T_NS / 2) clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic dout_a, dout_b, stim_a, stim_b, busy_a, busy_b, done_a, done_b, to_a, to_b;
  logic [7:0] lh_a, hl_a, lh_b, hl_b;

  int dr_a = 37, df_a = 25, dr_b = 12, df_b = 12;
  logic gut_a = 1'b1;
  logic gut_b = 1'b0;
  logic cst_en_b = 1'b0, cst_v_b = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Inverting GUT on instance A, buffer GUT (or a forced level) on instance B.
  always @(stim_a) begin
    if (stim_a === 1'b1) begin #(dr_a); gut_a = 1'b0; end
    else begin #(df_a); gut_a = 1'b1; end
  end
  always @(stim_b) begin
    if (stim_b === 1'b1) begin #(dr_b); gut_b = 1'b1; end
    else begin #(df_b); gut_b = 1'b0; end
  end
  assign dout_a = gut_a;
  assign dout_b = cst_en_b ? cst_v_b : gut_b;

  gate_delay_meter #(.CNT_W(8), .SETTLE(16), .TIMEOUT(TMO_A), .INVERTING(1'b1)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .dut_out(dout_a), .stim(stim_a),
    .busy(busy_a), .done(done_a), .lh_cycles(lh_a), .hl_cycles(hl_a), .timeout(to_a)
  );

  gate_delay_meter #(.CNT_W(8), .SETTLE(1), .TIMEOUT(TMO_B), .INVERTING(1'b0)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .dut_out(dout_b), .stim(stim_b),
    .busy(busy_b), .done(done_b), .lh_cycles(lh_b), .hl_cycles(hl_b), .timeout(to_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic obs_t obs(input int k);
    obs_t o;
    if (k == 0) o = '{stim_a, busy_a, done_a, lh_a, hl_a, to_a};
    else        o = '{stim_b, busy_b, done_b, lh_b, hl_b, to_b};
    return o;
  endfunction

  task automatic set_start(input int k, input logic v);
    if (k == 0) start_a = v; else start_b = v;
  endtask

  // Reported value from a raw count, applying the optional synchroniser compensation.
  function automatic int adj(input int v, input int tmo);
`ifdef GATE_DELAY_SYNC_COMP_EN
    if (v == tmo || v == 0) return v;
    return v - 1;
`else
    return v;
`endif
  endfunction

  // Reference: a change d ns after the stimulus edge is seen ceil(d/T)+1 cycles later.
  function automatic int model_cnt(input int d, input int tmo);
    int raw;
    raw = (d + T_NS - 1) / T_NS + 1;
    return (raw >= tmo) ? tmo : raw;
  endfunction

  task automatic run(input int k, input string tag, output logic [7:0] lh,
                     output logic [7:0] hl, output logic to);
    obs_t o;
    int n;
    @(negedge clk); set_start(k, 1'b1);
    @(negedge clk); set_start(k, 1'b0);
    o = obs(k);
    check({tag, "_busy_after_start"}, o.busy, 1);
    check({tag, "_timeout_cleared"}, o.to, 0);
    check({tag, "_lh_cleared"}, o.lh, 0);
    n = 0;
    while (o.done !== 1'b1 && n < 3000) begin
      @(negedge clk); o = obs(k); n++;
    end
    check({tag, "_done_seen"}, o.done, 1);
    lh = o.lh; hl = o.hl; to = o.to;
    @(negedge clk); o = obs(k);
    check({tag, "_done_one_cycle"}, o.done, 0);
    check({tag, "_busy_released"}, o.busy, 0);
    check({tag, "_stim_idle"}, o.stim, 0);
  endtask

  initial begin
    #(100_000 * T_NS);
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    logic [7:0] lh, hl;
    logic to;
    obs_t o;
    int dones, n;
    bit got;

    tbl[0] = '{0, 1'b0, 1'b0, 37, 25, 5, 4, 1'b0};
    tbl[1] = '{1, 1'b1, 1'b0, 12, 12, TMO_B, 0, 1'b1};
    tbl[2] = '{1, 1'b0, 1'b0, 12, 12, 3, 3, 1'b0};
    tbl[3] = '{1, 1'b0, 1'b0, 12, 12, 3, 3, 1'b0};
    tbl[4] = '{1, 1'b0, 1'b0, 3, 3, 2, 2, 1'b0};
    tbl[5] = '{1, 1'b1, 1'b1, 3, 3, 0, TMO_B, 1'b1};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      o = obs(k);
      check($sformatf("reset_stim_%0d", k), o.stim, 0);
      check($sformatf("reset_busy_%0d", k), o.busy, 0);
      check($sformatf("reset_done_%0d", k), o.done, 0);
      check($sformatf("reset_lh_%0d", k), o.lh, 0);
      check($sformatf("reset_hl_%0d", k), o.hl, 0);
      check($sformatf("reset_to_%0d", k), o.to, 0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      int tmo;
      tmo = (tbl[i].inst == 0) ? TMO_A : TMO_B;
      if (tbl[i].inst == 0) begin dr_a = tbl[i].dr; df_a = tbl[i].df; end
      else begin
        dr_b = tbl[i].dr; df_b = tbl[i].df;
        cst_en_b = tbl[i].cst_en; cst_v_b = tbl[i].cst_v;
      end
      repeat (4) @(negedge clk);
      run(tbl[i].inst, $sformatf("vec%0d", i), lh, hl, to);
      check($sformatf("vec%0d_lh", i), lh, adj(tbl[i].lh, tmo));
      check($sformatf("vec%0d_hl", i), hl, adj(tbl[i].hl, tmo));
      check($sformatf("vec%0d_timeout", i), to, tbl[i].to);
      repeat (3) @(negedge clk);
      o = obs(tbl[i].inst);
      check($sformatf("vec%0d_lh_hold", i), o.lh, adj(tbl[i].lh, tmo));
    end
    cst_en_b = 1'b0;

    // start held every cycle during a measurement: one done, same results.
    dr_a = 37; df_a = 25; dones = 0; got = 0; lh = '0; hl = '0;
    @(negedge clk);
    for (n = 0; n < 300; n++) begin
      start_a = !got;
      @(negedge clk);
      if (done_a === 1'b1) begin
        dones++; got = 1; lh = lh_a; hl = hl_a;
      end
    end
    start_a = 1'b0;
    check("repulse_done_count", dones, 1);
    check("repulse_lh", lh, adj(5, TMO_A));
    check("repulse_hl", hl, adj(4, TMO_A));

    // Reset while measuring the falling edge aborts without a done pulse.
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    n = 0;
    while (stim_a !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    while (stim_a !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("abort_reached_meas_hl", (n < 500), 1);
    rst_a = 1'b1;
    @(negedge clk); rst_a = 1'b0;
    check("abort_stim", stim_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_lh", lh_a, 0);
    check("abort_hl", hl_a, 0);
    check("abort_to", to_a, 0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done_a === 1'b1) dones++; end
    check("abort_no_done", dones, 0);
    run(0, "after_abort", lh, hl, to);
    check("after_abort_lh", lh, adj(5, TMO_A));
    check("after_abort_hl", hl, adj(4, TMO_A));

    // start coinciding with rst is discarded.
    @(negedge clk); rst_b = 1'b1; start_b = 1'b1;
    @(negedge clk); rst_b = 1'b0; start_b = 1'b0;
    check("rst_wins_busy", busy_b, 0);
    @(negedge clk);
    check("rst_wins_busy_later", busy_b, 0);
    check("rst_wins_stim", stim_b, 0);

    // Randomised delays on the inverting instance against the ceil model.
    for (int r = 0; r < 8; r++) begin
      dr_a = 10 * $urandom_range(0, 20) + $urandom_range(1, 9);
      df_a = 10 * $urandom_range(0, 20) + $urandom_range(1, 9);
      run(0, $sformatf("rand%0d", r), lh, hl, to);
      check($sformatf("rand%0d_lh_d%0d", r, dr_a), lh, adj(model_cnt(dr_a, TMO_A), TMO_A));
      check($sformatf("rand%0d_hl_d%0d", r, df_a), hl, adj(model_cnt(df_a, TMO_A), TMO_A));
      check($sformatf("rand%0d_timeout", r), to, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
